// File: rtl/tick_monitor.sv
// Tick spacing monitor: checks each upstream tick against a [MIN_GAP, MAX_GAP] window.
// Build option: define TICK_MON_STICKY_EN to hold early_err/late_err until clr or rst.
module tick_monitor #(
  parameter int MIN_GAP = 400000,
  parameter int MAX_GAP = 400002,
  parameter int GBITS   = 20,
  parameter int TBITS   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig,
  input  logic             clr,
  output logic             alive,
  output logic             early_err,
  output logic             late_err,
  output logic [GBITS-1:0] last_gap,
  output logic [TBITS-1:0] tick_cnt
);

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [GBITS-1:0] MIN_G   = GBITS'(MIN_GAP);
  localparam logic [GBITS-1:0] MAX_G   = GBITS'(MAX_GAP);
  localparam logic [GBITS-1:0] GAP_SAT = '1;

  state_t           state_reg, state_next;
  logic [GBITS-1:0] gap_cnt_reg, gap_cnt_next;
  logic [GBITS-1:0] last_gap_reg, last_gap_next;
  logic [TBITS-1:0] tick_cnt_reg, tick_cnt_next;
  logic             alive_reg, alive_next;
  logic             early_err_reg, early_err_next;
  logic             late_err_reg, late_err_next;
  logic             accept, early_ev, late_ev;

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    early_ev   = 1'b0;
    late_ev    = 1'b0;

    // gap_cnt restarts on every tick and every resync, otherwise saturates upward
    if (sig || clr) begin
      gap_cnt_next = GBITS'(1);
    end else if (gap_cnt_reg != GAP_SAT) begin
      gap_cnt_next = gap_cnt_reg + GBITS'(1);
    end else begin
      gap_cnt_next = gap_cnt_reg;
    end

    if (clr) begin
      state_next = SYNC;
    end else begin
      case (state_reg)
        SYNC: begin
          if (sig) begin
            accept     = 1'b1;
            state_next = RUN;
          end else if (gap_cnt_reg == MAX_G) begin
            late_ev    = 1'b1;
            state_next = FAULT;
          end
        end
        RUN: begin
          if (sig) begin
            if (gap_cnt_reg < MIN_G) begin
              early_ev   = 1'b1;
              state_next = FAULT;
            end else if (gap_cnt_reg <= MAX_G) begin
              accept = 1'b1;
            end else begin
              late_ev    = 1'b1;
              state_next = FAULT;
            end
          end else if (gap_cnt_reg >= MAX_G) begin
            late_ev    = 1'b1;
            state_next = FAULT;
          end
        end
        default: begin
          state_next = FAULT;
        end
      endcase
    end

    last_gap_next = accept ? gap_cnt_reg : last_gap_reg;
    tick_cnt_next = accept ? tick_cnt_reg + TBITS'(1) : tick_cnt_reg;
    alive_next    = (state_next == RUN);

`ifdef TICK_MON_STICKY_EN
    // flags latch until a resync; FAULT cannot raise a second one
    early_err_next = early_ev | (early_err_reg & ~clr);
    late_err_next  = late_ev  | (late_err_reg  & ~clr);
`else
    early_err_next = early_ev;
    late_err_next  = late_ev;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= SYNC;
      gap_cnt_reg   <= GBITS'(1);
      last_gap_reg  <= '0;
      tick_cnt_reg  <= '0;
      alive_reg     <= 1'b0;
      early_err_reg <= 1'b0;
      late_err_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      gap_cnt_reg   <= gap_cnt_next;
      last_gap_reg  <= last_gap_next;
      tick_cnt_reg  <= tick_cnt_next;
      alive_reg     <= alive_next;
      early_err_reg <= early_err_next;
      late_err_reg  <= late_err_next;
    end
  end

  assign alive     = alive_reg;
  assign early_err = early_err_reg;
  assign late_err  = late_err_reg;
  assign last_gap  = last_gap_reg;
  assign tick_cnt  = tick_cnt_reg;

endmodule

// File: tb/tb_tick_monitor.sv
// Bench for tick_monitor: time-stamp reference model checked every cycle, plus directed literal checks.
module tb_tick_monitor;

  localparam int MIN_GAP = 4;
  localparam int MAX_GAP = 6;
  localparam int GBITS   = 4;
  localparam int TBITS   = 3;

`ifdef TICK_MON_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             sig = 1'b0;
  logic             clr = 1'b0;
  logic             alive, early_err, late_err;
  logic [GBITS-1:0] last_gap;
  logic [TBITS-1:0] tick_cnt;

  int n_vec = 0;
  int n_bad = 0;

  tick_monitor #(
    .MIN_GAP(MIN_GAP),
    .MAX_GAP(MAX_GAP),
    .GBITS  (GBITS),
    .TBITS  (TBITS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig      (sig),
    .clr      (clr),
    .alive    (alive),
    .early_err(early_err),
    .late_err (late_err),
    .last_gap (last_gap),
    .tick_cnt (tick_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference model: tracks the time of the last tick/resync and derives the gap from it.
  localparam int M_SYNC = 0, M_RUN = 1, M_FAULT = 2;
  int cyc = 0;
  int anchor = 0;
  int mode = M_SYNC;
  bit m_valid = 1'b0;
  int m_cnt = 0, m_last = 0;
  bit m_alive = 1'b0, m_early = 1'b0, m_late = 1'b0;

  always @(posedge clk) begin : model
    int gap;
    bit ev_e, ev_l;
    cyc++;
    gap = cyc - anchor;
    if (gap > (1 << GBITS) - 1) gap = (1 << GBITS) - 1;
    ev_e = 1'b0;
    ev_l = 1'b0;
    if (rst) begin
      m_valid = 1'b1;
      mode    = M_SYNC;
      anchor  = cyc;
      m_cnt   = 0;
      m_last  = 0;
      m_early = 1'b0;
      m_late  = 1'b0;
    end else begin
      if (clr) begin
        mode = M_SYNC;
      end else if (mode == M_SYNC) begin
        if (sig) begin
          mode   = M_RUN;
          m_last = gap;
          m_cnt  = (m_cnt + 1) % (1 << TBITS);
        end else if (gap == MAX_GAP) begin
          ev_l = 1'b1;
          mode = M_FAULT;
        end
      end else if (mode == M_RUN) begin
        if (sig && gap < MIN_GAP) begin
          ev_e = 1'b1;
          mode = M_FAULT;
        end else if (sig) begin
          m_last = gap;
          m_cnt  = (m_cnt + 1) % (1 << TBITS);
        end else if (gap >= MAX_GAP) begin
          ev_l = 1'b1;
          mode = M_FAULT;
        end
      end
      if (STICKY) begin
        m_early = ev_e | (m_early & !clr);
        m_late  = ev_l | (m_late & !clr);
      end else begin
        m_early = ev_e;
        m_late  = ev_l;
      end
      if (sig || clr) anchor = cyc;
    end
    m_alive = (mode == M_RUN);
  end

  always @(negedge clk) begin : compare
    if (m_valid) begin
      check("alive",     int'(alive),     int'(m_alive));
      check("early_err", int'(early_err), int'(m_early));
      check("late_err",  int'(late_err),  int'(m_late));
      check("last_gap",  int'(last_gap),  m_last);
      check("tick_cnt",  int'(tick_cnt),  m_cnt);
    end
  end

  task automatic tick(input bit s, input bit c, input bit r);
    sig = s;
    clr = c;
    rst = r;
    @(posedge clk);
    #1;
    sig = 1'b0;
    clr = 1'b0;
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0, 1'b0);
  endtask

  int cd;
  bit rs, rc, rr;

  initial begin
    // reset state
    tick(1'b0, 1'b0, 1'b1);
    check("rst_alive", int'(alive), 0);
    check("rst_cnt", int'(tick_cnt), 0);
    check("rst_gap", int'(last_gap), 0);
    check("rst_errs", int'(early_err) + int'(late_err), 0);

    // ten ticks spaced 5 clocks apart; counter wraps 7 -> 0
    for (int i = 0; i < 10; i++) begin
      idle(4);
      tick(1'b1, 1'b0, 1'b0);
      if (i == 0) check("first_alive", int'(alive), 1);
    end
    check("run_gap", int'(last_gap), 5);
    check("run_cnt", int'(tick_cnt), 2);
    check("run_errs", int'(early_err) + int'(late_err), 0);

    // early tick at gap 3
    idle(2);
    tick(1'b1, 1'b0, 1'b0);
    check("early_flag", int'(early_err), 1);
    check("early_alive", int'(alive), 0);
    check("early_gap", int'(last_gap), 5);
    tick(1'b0, 1'b0, 1'b0);
    check("early_hold", int'(early_err), STICKY ? 1 : 0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    check("fault_ignore_cnt", int'(tick_cnt), 2);
    check("fault_alive", int'(alive), 0);

    // clr with same-cycle sig, then accepted tick at gap 2
    tick(1'b1, 1'b1, 1'b0);
    idle(1);
    tick(1'b1, 1'b0, 1'b0);
    check("resync_alive", int'(alive), 1);
    check("resync_gap", int'(last_gap), 2);
    check("resync_cnt", int'(tick_cnt), 3);
    check("resync_early", int'(early_err), 0);

    // reset mid-RUN
    idle(2);
    tick(1'b0, 1'b0, 1'b1);
    check("midrst_cnt", int'(tick_cnt), 0);
    check("midrst_gap", int'(last_gap), 0);
    check("midrst_alive", int'(alive), 0);

    // missing tick: late_err after gap 6 with no sig
    idle(4);
    tick(1'b1, 1'b0, 1'b0);
    check("relock_alive", int'(alive), 1);
    idle(5);
    tick(1'b0, 1'b0, 1'b0);
    check("late_flag", int'(late_err), 1);
    check("late_alive", int'(alive), 0);
    check("late_early", int'(early_err), 0);
    tick(1'b1, 1'b0, 1'b0);
    check("late_gap7_alive", int'(alive), 0);
    check("late_hold", int'(late_err), STICKY ? 1 : 0);
    check("late_cnt", int'(tick_cnt), 1);

    // gap boundaries 4 and 6 accepted, 3 rejected
    tick(1'b0, 1'b1, 1'b0);
    check("clr_late", int'(late_err), 0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    idle(3);
    tick(1'b1, 1'b0, 1'b0);
    check("gap4_gap", int'(last_gap), 4);
    check("gap4_cnt", int'(tick_cnt), 3);
    idle(5);
    tick(1'b1, 1'b0, 1'b0);
    check("gap6_gap", int'(last_gap), 6);
    check("gap6_alive", int'(alive), 1);
    check("gap6_late", int'(late_err), 0);
    idle(2);
    tick(1'b1, 1'b0, 1'b0);
    check("gap3_early", int'(early_err), 1);
    check("gap3_gap", int'(last_gap), 6);
    tick(1'b0, 1'b1, 1'b0);

    // randomized traffic, mostly in-window gaps with occasional glitches, clr and rst
    cd = 5;
    for (int i = 0; i < 4000; i++) begin
      cd--;
      rs = (cd <= 0);
      if (rs) cd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8))
                                               : int'($urandom_range(MIN_GAP, MAX_GAP));
      if ($urandom_range(0, 19) == 0) rs = 1'b1;
      rc = ($urandom_range(0, 39) == 0);
      rr = ($urandom_range(0, 499) == 0);
      tick(rs, rc, rr);
    end

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/tick_monitor.md
Name: tick_monitor

Overview:
- Sits directly downstream of the free-running tick generator, which emits a 1-cycle tick every N+1 clocks.
- Checks each tick's spacing against a [MIN_GAP, MAX_GAP] window and flags early or missing ticks.
- Counts good ticks and reports the last measured gap.
- Drives a liveness indication (alive) for the rest of the design.

Parameters:
- MIN_GAP, 400000: smallest legal tick-to-tick gap, in clocks.
- MAX_GAP, 400002: largest legal gap, in clocks. Must satisfy MIN_GAP <= MAX_GAP < 2^GBITS - 1.
- GBITS, 20: width of the gap counter and of last_gap.
- TBITS, 16: width of tick_cnt.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous active-high reset.
- sig  in  1  tick from the upstream generator; a 1-cycle pulse is expected.
- clr  in  1  synchronous fault clear / resync request.
- alive  out  1  high while in RUN.
- early_err  out  1  tick arrived with gap < MIN_GAP.
- late_err  out  1  no tick by gap MAX_GAP.
- last_gap  out  GBITS  gap of the most recent accepted tick.
- tick_cnt  out  TBITS  number of accepted ticks; wraps modulo 2^TBITS.

Behaviour:
- Reset: one clock; reset is synchronous and active-high.
  - rst high sets state=SYNC, gap_cnt=1, alive=0, early_err=0, late_err=0, last_gap=0, tick_cnt=0.
  - rst overrides all other inputs, including mid-operation.
- gap_cnt:
  - Set to 1 in any cycle where sig=1 or clr=1.
  - Otherwise incremented, saturating at 2^GBITS-1.
  - Therefore, on a tick cycle, gap_cnt equals the clocks since the previous tick, or since the reset/clr release.
- All outputs are registered. Flags reflect events of the previous cycle (1-cycle latency).
- State SYNC (after reset or clr):
  - sig=1: go to RUN. Gap is not checked against MIN_GAP; last_gap<=gap_cnt; tick_cnt++.
  - sig=0 and gap_cnt==MAX_GAP: late_err pulse, go to FAULT.
- State RUN:
  - sig=1 and gap_cnt<MIN_GAP: early_err pulse, go to FAULT. last_gap and tick_cnt are unchanged.
  - sig=1 and MIN_GAP<=gap_cnt<=MAX_GAP: stay in RUN; last_gap<=gap_cnt; tick_cnt++.
  - sig=0 and gap_cnt==MAX_GAP: late_err pulse, go to FAULT.
- State FAULT:
  - alive=0; sig is ignored (no count, no last_gap update, no further error pulses).
  - Stays in FAULT until clr.
- clr in any state: go to SYNC, gap_cnt=1. clr has priority over a same-cycle sig, which is discarded.
- alive is 1 exactly in the cycles after entering RUN, until leaving it.
- A sig held high for k cycles in RUN: first cycle is evaluated normally; the second has gap_cnt=1 < MIN_GAP, giving early_err and FAULT (when MIN_GAP>1).
- tick_cnt wraps from 2^TBITS-1 to 0 without any flag.
- early_err and late_err are never asserted in the same cycle.

Optional Feature:
- Macro TICK_MON_STICKY_EN.
- Defined: early_err and late_err stay high from assertion until clr or rst clears them. A second fault is impossible while in FAULT.
- Undefined: early_err and late_err are single-cycle pulses.

Test Plan (overrides: MIN_GAP=4, MAX_GAP=6, GBITS=4, TBITS=3):
- Reset, then sig every 5 clocks for 10 ticks -> alive=1 after the first tick; last_gap=5; tick_cnt wraps 7->0 and ends at 2; no error flags.
- In RUN, sig at gap 3 -> early_err high 1 cycle (held high if STICKY); alive=0; last_gap stays 5; later ticks ignored.
- In RUN, no sig for 6 clocks -> late_err in the cycle after gap_cnt==6; FAULT entered; a sig at gap 7 does not restore alive.
- In FAULT, assert clr together with sig -> SYNC; sig discarded; next sig 2 clocks later is accepted (no MIN check); alive=1, last_gap=2.
- rst asserted mid-RUN with tick_cnt=3 -> next cycle: tick_cnt=0, last_gap=0, alive=0, state SYNC.
- Gap boundaries -> gap 4 and gap 6 accepted; gap 3 gives early_err; reaching gap 6 with no tick gives late_err.
